// File: rtl/dft_frame_sequencer_if.sv
// Sample-stream and engine-side bundle for dft_frame_sequencer.
// master = sample source / engine side, slave = the sequencer.
interface dft_frame_sequencer_if #(
  parameter int DIN_WIDTH       = 16,
  parameter int PARALLEL_INPUTS = 2
);
  localparam int LW = DIN_WIDTH * PARALLEL_INPUTS;

  logic          sync_in;
  logic [LW-1:0] din_re;
  logic [LW-1:0] din_im;
  logic          din_valid;
  logic [LW-1:0] dft_din_re;
  logic [LW-1:0] dft_din_im;
  logic          dft_din_valid;
  logic          dft_rst;
  logic [31:0]   delay_line;
  logic          dft_dout_valid;

  modport master (
    output sync_in, din_re, din_im, din_valid, dft_dout_valid,
    input  dft_din_re, dft_din_im, dft_din_valid, dft_rst, delay_line
  );

  modport slave (
    input  sync_in, din_re, din_im, din_valid, dft_dout_valid,
    output dft_din_re, dft_din_im, dft_din_valid, dft_rst, delay_line
  );
endinterface

// File: rtl/dft_frame_sequencer.sv
// Frame-level run controller in front of the DFT bin engine: sync alignment, frame gating, result tracking.
// Optional mid-frame sync detection is enabled with `define DFT_SEQ_SYNC_CHECK_EN.
module dft_frame_sequencer #(
  parameter int DIN_WIDTH       = 16,
  parameter int PARALLEL_INPUTS = 2,
  parameter int DFT_LEN         = 128,
  parameter int MIN_LEN         = 4,
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int FLUSH_TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [31:0]                cfg_len_m1,
  input  logic [FRAME_CNT_WIDTH-1:0] cfg_frames,
  dft_frame_sequencer_if.slave       bus,
  output logic                       busy,
  output logic                       done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic [FRAME_CNT_WIDTH-1:0] result_cnt,
  output logic                       err_cfg,
  output logic                       err_timeout,
  output logic                       sync_err
);
  localparam int FW = FRAME_CNT_WIDTH;
  localparam int LW = DIN_WIDTH * PARALLEL_INPUTS;
  localparam int SW = (DFT_LEN > 2) ? $clog2(DFT_LEN) : 1;
  localparam int TW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [31:0]   LEN_MIN = 32'(MIN_LEN - 1);
  localparam logic [31:0]   LEN_MAX = 32'(DFT_LEN - 1);
  localparam logic [TW-1:0] TMO     = TW'(FLUSH_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, FLUSH} state_t;

  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
    return (&v) ? v : v + FW'(1);
  endfunction

  state_t        state;
  logic [31:0]   len_q;
  logic [FW-1:0] frames_q;
  logic [SW-1:0] samp_cnt;
  logic [TW-1:0] flush_cnt;
  logic          stop_pend;
  logic          dft_rst_q;
  logic [LW-1:0] re_p1;
  logic [LW-1:0] im_p1;
  logic          vld_p1;

  logic          cfg_ok;
  logic          gate;
  logic          wrap;
  logic          last_frame;
  logic [FW-1:0] frame_inc;
  logic [FW-1:0] rc_n;
  logic [TW-1:0] fc_n;

  always_comb begin
    cfg_ok     = (cfg_len_m1 >= LEN_MIN) && (cfg_len_m1 <= LEN_MAX);
    // A stop in ARMED aborts the run, so the coincident sync sample is not passed on.
    gate       = (state == RUN) || ((state == ARMED) && bus.sync_in && !stop);
    wrap       = (state == RUN) && bus.din_valid && (samp_cnt == len_q[SW-1:0]);
    frame_inc  = sat_inc(frame_cnt);
    last_frame = (frames_q != '0) && (frame_inc == frames_q);
    rc_n       = (((state == RUN) || (state == FLUSH)) && bus.dft_dout_valid)
                 ? sat_inc(result_cnt) : result_cnt;
    fc_n       = flush_cnt + TW'(1);
  end

  // Stage p1: sample register toward the engine
  always_ff @(posedge clk) begin
    if (rst) begin
      re_p1  <= '0;
      im_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      re_p1  <= bus.din_re;
      im_p1  <= bus.din_im;
      vld_p1 <= bus.din_valid && gate;
    end
  end

  assign bus.dft_din_re    = re_p1;
  assign bus.dft_din_im    = im_p1;
  assign bus.dft_din_valid = vld_p1;
  assign bus.dft_rst       = dft_rst_q;
  assign bus.delay_line    = len_q;

  // done is raised one edge early so it is visible on the last FLUSH cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      dft_rst_q   <= 1'b0;
      len_q       <= LEN_MAX;
      frames_q    <= '0;
      samp_cnt    <= '0;
      flush_cnt   <= '0;
      stop_pend   <= 1'b0;
      frame_cnt   <= '0;
      result_cnt  <= '0;
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done       <= 1'b0;
      dft_rst_q  <= 1'b0;
      result_cnt <= rc_n;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              len_q       <= cfg_len_m1;
              frames_q    <= cfg_frames;
              frame_cnt   <= '0;
              result_cnt  <= '0;
              samp_cnt    <= '0;
              stop_pend   <= 1'b0;
              err_cfg     <= 1'b0;
              err_timeout <= 1'b0;
              dft_rst_q   <= 1'b1;
              busy        <= 1'b1;
              state       <= ARMED;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (bus.sync_in && bus.din_valid) begin
            samp_cnt <= SW'(1);
            state    <= RUN;
          end
        end
        RUN: begin
          if (stop) stop_pend <= 1'b1;
          if (wrap) begin
            samp_cnt  <= '0;
            frame_cnt <= frame_inc;
            if (last_frame || stop_pend || stop) begin
              stop_pend <= 1'b0;
              flush_cnt <= '0;
              state     <= FLUSH;
              if ((rc_n == frame_inc) || (TMO == '0)) begin
                done        <= 1'b1;
                err_timeout <= (rc_n != frame_inc);
              end
            end
          end else if (bus.din_valid) begin
            samp_cnt <= samp_cnt + SW'(1);
          end
        end
        FLUSH: begin
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            flush_cnt <= fc_n;
            if ((rc_n == frame_cnt) || (fc_n == TMO)) begin
              done <= 1'b1;
              if (rc_n != frame_cnt) err_timeout <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DFT_SEQ_SYNC_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else if ((state == IDLE) && start && cfg_ok) begin
      sync_err <= 1'b0;
    end else if ((state == RUN) && bus.din_valid && bus.sync_in && (samp_cnt != '0)) begin
      sync_err <= 1'b1;
    end
  end
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_dft_frame_sequencer.sv
// Directed scoreboard bench for dft_frame_sequencer: forwarded samples queued at drive time, popped at output.
module tb_dft_frame_sequencer;
  localparam int DW = 16;
  localparam int PI = 2;
  localparam int LW = DW * PI;
  localparam int FW = 16;
`ifdef DFT_SEQ_SYNC_CHECK_EN
  localparam logic SYNC_CHK = 1'b1;
`else
  localparam logic SYNC_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [31:0]   cfg_len_m1;
  logic [FW-1:0] cfg_frames;
  logic          busy;
  logic          done;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] result_cnt;
  logic          err_cfg;
  logic          err_timeout;
  logic          sync_err;

  int vectors     = 0;
  int miscompares = 0;
  logic [2*LW-1:0] q[$];

  dft_frame_sequencer_if #(.DIN_WIDTH(DW), .PARALLEL_INPUTS(PI)) bus ();

  dft_frame_sequencer #(
    .DIN_WIDTH(DW), .PARALLEL_INPUTS(PI), .DFT_LEN(128), .MIN_LEN(4),
    .FRAME_CNT_WIDTH(FW), .FLUSH_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_len_m1(cfg_len_m1), .cfg_frames(cfg_frames), .bus(bus),
    .busy(busy), .done(done), .frame_cnt(frame_cnt), .result_cnt(result_cnt),
    .err_cfg(err_cfg), .err_timeout(err_timeout), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic fwd);
    logic [2*LW-1:0] e;
    @(posedge clk);
    #1;
    check("dft_din_valid", 64'(bus.dft_din_valid), 64'(fwd));
    if (fwd && (q.size() > 0)) begin
      e = q.pop_front();
      if (bus.dft_din_valid === 1'b1) begin
        check("dft_din_re", 64'(bus.dft_din_re), 64'(e[2*LW-1:LW]));
        check("dft_din_im", 64'(bus.dft_din_im), 64'(e[LW-1:0]));
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic dv, input logic fwd);
    logic [LW-1:0] r;
    logic [LW-1:0] i;
    r = LW'($urandom);
    i = LW'($urandom);
    bus.din_valid      = v;
    bus.sync_in        = s;
    bus.dft_dout_valid = dv;
    bus.din_re         = r;
    bus.din_im         = i;
    if (fwd) q.push_back({r, i});
    tick(fwd);
  endtask

  task automatic do_start(input logic [31:0] len, input logic [FW-1:0] frames, input logic with_stop);
    cfg_len_m1 = len;
    cfg_frames = frames;
    start      = 1'b1;
    stop       = with_stop;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    start      = 1'b0;
    stop       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_len_m1 = '0; cfg_frames = '0;
    bus.din_valid = 1'b0; bus.sync_in = 1'b0; bus.dft_dout_valid = 1'b0;
    bus.din_re = '0; bus.din_im = '0;

    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dft_rst", 64'(bus.dft_rst), 64'(0));
    check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    check("rst_result_cnt", 64'(result_cnt), 64'(0));
    check("rst_err_cfg", 64'(err_cfg), 64'(0));
    check("rst_err_timeout", 64'(err_timeout), 64'(0));
    check("rst_sync_err", 64'(sync_err), 64'(0));
    check("rst_delay_line", 64'(bus.delay_line), 64'(127));
    check("rst_data_re", 64'(bus.dft_din_re), 64'(0));
    rst = 1'b0;

    // len 8, 3 frames, results returned in FLUSH
    do_start(32'd7, 16'd3, 1'b0);
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_dft_rst", 64'(bus.dft_rst), 64'(1));
    check("t1_delay_line", 64'(bus.delay_line), 64'(7));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_dft_rst_once", 64'(bus.dft_rst), 64'(0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 24; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      if (k == 7) check("t1_frame_cnt_1", 64'(frame_cnt), 64'(1));
    end
    check("t1_frame_cnt", 64'(frame_cnt), 64'(3));
    check("t1_flush_busy", 64'(busy), 64'(1));
    check("t1_result_cnt0", 64'(result_cnt), 64'(0));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t1_not_done", 64'(done), 64'(0));
    check("t1_result_cnt2", 64'(result_cnt), 64'(2));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t1_done", 64'(done), 64'(1));
    check("t1_done_busy", 64'(busy), 64'(1));
    check("t1_result_cnt3", 64'(result_cnt), 64'(3));
    check("t1_err_timeout", 64'(err_timeout), 64'(0));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_done_pulse", 64'(done), 64'(0));
    check("t1_idle_busy", 64'(busy), 64'(0));

    // illegal lengths, engine results ignored in IDLE
    do_start(32'd2, 16'd1, 1'b0);
    check("t2_err_cfg_lo", 64'(err_cfg), 64'(1));
    check("t2_busy_lo", 64'(busy), 64'(0));
    check("t2_delay_lo", 64'(bus.delay_line), 64'(7));
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t2_busy_stay", 64'(busy), 64'(0));
    do_start(32'd128, 16'd1, 1'b0);
    check("t2_err_cfg_hi", 64'(err_cfg), 64'(1));
    check("t2_delay_hi", 64'(bus.delay_line), 64'(7));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_result_ignored", 64'(result_cnt), 64'(3));

    // continuous run ended by stop mid-frame
    do_start(32'd15, 16'd0, 1'b0);
    check("t3_err_cfg_clr", 64'(err_cfg), 64'(0));
    check("t3_result_clr", 64'(result_cnt), 64'(0));
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 16; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k == 9) begin
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_result_in_run", 64'(result_cnt), 64'(1));
      end
      step(1'b1, 1'b0, 1'b0, 1'b1);
    end
    check("t3_frame_cnt2", 64'(frame_cnt), 64'(2));
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    stop = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    stop = 1'b0;
    for (int k = 6; k < 16; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_frame_cnt", 64'(frame_cnt), 64'(3));
    check("t3_flush_busy", 64'(busy), 64'(1));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_done", 64'(done), 64'(1));
    check("t3_err_timeout", 64'(err_timeout), 64'(0));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_idle_busy", 64'(busy), 64'(0));

    // minimum length, 2 frames, no results -> timeout
    do_start(32'd3, 16'd2, 1'b0);
    check("t4_busy", 64'(busy), 64'(1));
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < 64; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_early_done", 64'(done), 64'(0));
    check("t4_early_tmo", 64'(err_timeout), 64'(0));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_done", 64'(done), 64'(1));
    check("t4_err_timeout", 64'(err_timeout), 64'(1));
    check("t4_frame_cnt", 64'(frame_cnt), 64'(2));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_idle_busy", 64'(busy), 64'(0));
    check("t4_tmo_sticky", 64'(err_timeout), 64'(1));

    // mid-frame sync, then reset mid-run
    do_start(32'd7, 16'd0, 1'b0);
    check("t5_tmo_clr", 64'(err_timeout), 64'(0));
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_sync_at_0", 64'(sync_err), 64'(0));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_sync_at_3", 64'(sync_err), 64'(SYNC_CHK));
    check("t5_frame_cnt", 64'(frame_cnt), 64'(1));
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_done", 64'(done), 64'(0));
    check("t5_rst_delay", 64'(bus.delay_line), 64'(127));
    check("t5_rst_frame_cnt", 64'(frame_cnt), 64'(0));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_no_done", 64'(done), 64'(0));

    // start with stop in IDLE: stop discarded
    do_start(32'd3, 16'd0, 1'b1);
    check("t6_busy", 64'(busy), 64'(1));
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("t6_still_run", 64'(busy), 64'(1));
    check("t6_frame_cnt", 64'(frame_cnt), 64'(1));
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // stop while ARMED aborts without done
    do_start(32'd3, 16'd1, 1'b0);
    stop = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    stop = 1'b0;
    check("t7_busy", 64'(busy), 64'(0));
    check("t7_done", 64'(done), 64'(0));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t7_idle", 64'(busy), 64'(0));

    check("queue_empty", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dft_frame_sequencer.md
# dft_frame_sequencer

Frame-level controller placed in front of the multi-input DFT bin engine. It latches a run configuration and resets the engine's counters. It aligns the first forwarded sample to an external frame sync, then gates the sample stream for a programmed number of DFT frames and drives the engine's `delay_line`. Finally it counts returned DFT results to confirm completion, with a timeout.

## Interface

Parameters:
- `DIN_WIDTH`, 16, width of one real or imaginary sample lane.
- `PARALLEL_INPUTS`, 2, number of sample lanes.
- `DFT_LEN`, 128, maximum DFT length; `delay_line` never exceeds `DFT_LEN-1`.
- `MIN_LEN`, 4, minimum legal DFT length.
- `FRAME_CNT_WIDTH`, 16, width of the frame and result counters.
- `FLUSH_TIMEOUT`, 64, cycles allowed in FLUSH for outstanding results.

Ports:
- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; arms a run from IDLE and is ignored in other states.
- `stop` in 1: one-cycle pulse; ends a continuous run at the next frame boundary.
- `cfg_len_m1` in 32: requested DFT length minus 1, sampled on `start`.
- `cfg_frames` in FRAME_CNT_WIDTH: number of frames to run, sampled on `start`; 0 means continuous.
- `sync_in` in 1: frame sync, qualified by `din_valid`.
- `din_re`, `din_im` in PARALLEL_INPUTS*DIN_WIDTH: sample stream.
- `din_valid` in 1: sample qualifier.
- `dft_din_re`, `dft_din_im` out PARALLEL_INPUTS*DIN_WIDTH: registered samples to the engine.
- `dft_din_valid` out 1: gated sample valid to the engine.
- `dft_rst` out 1: reset to the engine.
- `delay_line` out 32: latched `cfg_len_m1`, sent to the engine.
- `dft_dout_valid` in 1: the engine's result valid.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `frame_cnt` out FRAME_CNT_WIDTH: frames issued in the current run.
- `result_cnt` out FRAME_CNT_WIDTH: results received in the current run.
- `err_cfg` out 1: sticky; set when `start` carried an illegal length.
- `err_timeout` out 1: sticky; set when FLUSH expired.
- `sync_err` out 1: sticky; present only under the macro, tied to 0 otherwise.

## Operation

States: IDLE, ARMED, RUN, FLUSH.

- **IDLE**
  - `start` with `MIN_LEN-1 <= cfg_len_m1 <= DFT_LEN-1`: latch the length and frame count, clear both counters, clear the sticky errors, go to ARMED.
  - `start` with an illegal length: set `err_cfg`, stay in IDLE, leave `delay_line` unchanged.
- **ARMED**
  - `dft_rst` is high on the first ARMED cycle only.
  - Wait for `sync_in && din_valid`. That sample is frame sample 0 and is forwarded. Go to RUN.
  - Samples before the sync are dropped.
- **RUN**
  - Every `din_valid` is forwarded.
  - The sample counter counts 0..len_m1 and wraps.
  - At the wrap, `frame_cnt` increments.
  - At a wrap where `frame_cnt+1 == cfg_frames` (nonzero), or where a stop is pending, forward the last sample and go to FLUSH.
  - `stop` is held pending until the next wrap.
  - `sync_in` is otherwise ignored (see Configuration).
- **FLUSH**
  - No samples are forwarded.
  - A cycle counter runs from 0.
  - When `result_cnt == frame_cnt`: pulse `done`, go to IDLE.
  - When the counter reaches `FLUSH_TIMEOUT` first: set `err_timeout`, pulse `done`, go to IDLE.

Counters and configuration:
- `result_cnt` increments on each `dft_dout_valid` in RUN or FLUSH.
- `dft_dout_valid` in IDLE or ARMED is ignored.
- All counters saturate at all-ones rather than wrapping.
- `delay_line` holds its value from the end of a run until the next valid `start`.

## Timing

- `dft_din_*` is `din_*` delayed by exactly 1 cycle.
- `dft_din_valid` is the 1-cycle-delayed `din_valid`, ANDed with the gate decided in that same cycle.
- `start` is accepted on cycle N. The state is ARMED and `dft_rst` is 1 on cycle N+1.
- The sync sample arrives on cycle M. The engine sees it on cycle M+1.
- The last frame sample arrives on cycle K. FLUSH begins on cycle K+1.
- `done` is high on the cycle FLUSH exits. `busy` is 0 on the following cycle.
- Reset values:
  - state IDLE; `busy`, `done`, `dft_rst`, `dft_din_valid` all 0; all counters and errors 0.
  - `delay_line` = `DFT_LEN-1`; data registers 0.
- `rst` in any state aborts the run with no `done` and returns to IDLE on the next cycle.
- `start` and `stop` together in IDLE: `start` wins, and `stop` is discarded.
- `stop` in ARMED returns to IDLE with no `done`.
- `dft_dout_valid` on the same cycle FLUSH expires is counted first. If the counts then match, `err_timeout` is not set.

## Configuration

- `DFT_SEQ_SYNC_CHECK_EN` defined:
  - `sync_in && din_valid` in RUN while the sample counter is not at 0 sets `sync_err`.
  - That sample is still forwarded and the counter is not realigned.
  - A sync exactly on sample 0 is legal.
- `DFT_SEQ_SYNC_CHECK_EN` not defined: `sync_in` is ignored in RUN and `sync_err` is tied to 0.

## Test plan

- `cfg_len_m1`=7, `cfg_frames`=3, continuous `din_valid`, sync on cycle 5 → 24 forwarded valids starting cycle 6, `frame_cnt`=3. Inject 3 `dft_dout_valid` → `done` pulses and `err_timeout`=0.
- `cfg_len_m1`=2 or `cfg_len_m1`=128 (with `DFT_LEN`=128) → `err_cfg`=1, `busy` stays 0, `delay_line` unchanged.
- `cfg_frames`=0, `cfg_len_m1`=15, `stop` at sample 5 of frame 2 → forwarding continues through sample 15, then FLUSH.
- `cfg_frames`=2 with no `dft_dout_valid` → `done` and `err_timeout`=1 exactly 64 cycles after FLUSH entry.
- With the macro, `cfg_len_m1`=7: sync at sample 3 → `sync_err`=1. Sync at sample 0 → `sync_err` stays 0.
- `rst` asserted mid-RUN → IDLE next cycle, `dft_din_valid`=0, `delay_line`=127, no `done`.
